// File: rtl/ga_pkg.sv
// Shared constants for the gate-array sync/interrupt slice: interrupt counter
// limits and RMR register bit positions.
package ga_pkg;

    localparam int INT_LINES      = 52;
    localparam int INT_RESYNC_MIN = 32;

    localparam int RMR_INT_RST = 4;
    localparam int RMR_MODE_HI = 1;
    localparam int RMR_MODE_LO = 0;

endpackage

// File: rtl/ga_sync_shaper.sv
// Saturating step counter with a windowed, level-gated output pulse; used for
// both monitor HSYNC (step every char) and monitor VSYNC (step every line).
module ga_sync_shaper #(
    parameter int CW    = 4,
    parameter int DELAY = 3,
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clken,
    input  logic          clr,
    input  logic          step,
    input  logic          level,
    output logic [CW-1:0] cnt,
    output logic          pulse
);

    localparam logic [CW-1:0] LO_C  = CW'(DELAY);
    localparam logic [CW-1:0] HI_C  = CW'(DELAY + WIDTH);
    localparam logic [CW-1:0] MAX_C = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] next_s;

    // next count: clear dominates, otherwise saturating increment on a step
    always_comb begin
        next_s = cnt;
        if (clr) begin
            next_s = {CW{1'b0}};
        end else if (step && level) begin
            next_s = (cnt == MAX_C) ? cnt : cnt + ONE_C;
        end else begin
            next_s = cnt;
        end
    end

    // count and pulse register, advanced only on the char-clock enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= {CW{1'b0}};
            pulse <= 1'b0;
        end else if (clken) begin
            cnt   <= next_s;
            pulse <= level & (next_s >= LO_C) & (next_s < HI_C);
        end
    end

endmodule

// File: rtl/ga_sync_int.sv
// Gate-array CRTC sync receiver: shaped monitor syncs, 52-line raster
// interrupt with VSYNC resync and acknowledge, and HSYNC-latched screen mode.
module ga_sync_int #(
    parameter int HS_DELAY  = 2,
    parameter int HS_WIDTH  = 4,
    parameter int VS_DELAY  = 2,
    parameter int VS_WIDTH  = 4,
    parameter int INT_LINES = ga_pkg::INT_LINES
) (
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       CLKEN,
    input  logic       HSYNC_IN,
    input  logic       VSYNC_IN,
    input  logic       INT_ACK,
    input  logic       RMR_WR,
    input  logic [4:0] RMR_DI,
    output logic       INT,
    output logic       HSYNC_OUT,
    output logic       VSYNC_OUT,
    output logic [1:0] MODE,
    output logic [5:0] R52
);
    import ga_pkg::*;

    localparam logic [5:0] WRAP_C       = 6'(INT_LINES);
    localparam logic [5:0] RESYNC_MIN_C = 6'(INT_RESYNC_MIN);
    localparam logic [2:0] RESYNC_PRE_C = 3'(VS_DELAY - 1);

    logic       hs_prev_r;
    logic       vs_prev_r;
    logic [1:0] mode_pend_r;
    logic [3:0] hs_cnt_s;
    logic [2:0] vs_cnt_s;
    logic       hs_fall_s;
    logic       vs_rise_s;
    logic       resync_s;
    logic       set_s;
    logic [5:0] inc_s;
    logic [5:0] r52_next_s;
    logic       int_next_s;

    assign hs_fall_s = CLKEN & hs_prev_r & ~HSYNC_IN;
    assign vs_rise_s = CLKEN & ~vs_prev_r & VSYNC_IN;
    // the falling edge that lifts the line count inside VSYNC to VS_DELAY
    assign resync_s  = hs_fall_s & VSYNC_IN & ~vs_rise_s & (vs_cnt_s == RESYNC_PRE_C);
    assign inc_s     = R52 + 6'd1;

    // HSYNC delay is counted from the first high sample, which already reads 1
    ga_sync_shaper #(.CW(4), .DELAY(HS_DELAY + 1), .WIDTH(HS_WIDTH)) u_hs (
        .clk   (CLOCK),
        .rst_n (nRESET),
        .clken (CLKEN),
        .clr   (~HSYNC_IN),
        .step  (1'b1),
        .level (HSYNC_IN),
        .cnt   (hs_cnt_s),
        .pulse (HSYNC_OUT)
    );

    ga_sync_shaper #(.CW(3), .DELAY(VS_DELAY), .WIDTH(VS_WIDTH)) u_vs (
        .clk   (CLOCK),
        .rst_n (nRESET),
        .clken (CLKEN),
        .clr   (vs_rise_s),
        .step  (hs_fall_s),
        .level (VSYNC_IN),
        .cnt   (vs_cnt_s),
        .pulse (VSYNC_OUT)
    );

    // interrupt counter next state: line step, then ack, then RMR reset on top
    always_comb begin
        r52_next_s = R52;
        int_next_s = INT;
        set_s      = 1'b0;
        if (hs_fall_s) begin
            if (resync_s) begin
                r52_next_s = 6'd0;
                if ((R52 >= RESYNC_MIN_C) || (inc_s == WRAP_C)) begin
                    int_next_s = 1'b1;
                    set_s      = 1'b1;
                end else begin
                    int_next_s = INT;
                end
            end else if (inc_s == WRAP_C) begin
                r52_next_s = 6'd0;
                int_next_s = 1'b1;
                set_s      = 1'b1;
            end else begin
                r52_next_s = inc_s;
            end
        end else begin
            r52_next_s = R52;
        end
        if (INT_ACK) begin
            r52_next_s[5] = 1'b0;
            int_next_s    = set_s;
        end else begin
            int_next_s = int_next_s;
        end
        if (RMR_WR && RMR_DI[RMR_INT_RST]) begin
            r52_next_s = 6'd0;
            int_next_s = 1'b0;
        end else begin
            r52_next_s = r52_next_s;
        end
    end

    // interrupt, mode latch and edge-history registers
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            INT         <= 1'b0;
            R52         <= 6'd0;
            MODE        <= 2'd0;
            mode_pend_r <= 2'd0;
            hs_prev_r   <= 1'b0;
            vs_prev_r   <= 1'b0;
        end else begin
            INT <= int_next_s;
            R52 <= r52_next_s;
            if (RMR_WR) begin
                mode_pend_r <= RMR_DI[RMR_MODE_HI:RMR_MODE_LO];
            end
            if (CLKEN) begin
                hs_prev_r <= HSYNC_IN;
                vs_prev_r <= VSYNC_IN;
                if (HSYNC_IN && (hs_cnt_s == 4'd0)) begin
                    MODE <= mode_pend_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_ga_sync_int.sv
// Randomised CRTC-like frames against a behavioural model; expected outputs are
// queued per clock and compared by an independent monitor after each edge.
module tb_ga_sync_int;

    localparam int HS_DELAY  = 2;
    localparam int HS_WIDTH  = 4;
    localparam int VS_DELAY  = 2;
    localparam int VS_WIDTH  = 4;
    localparam int INT_LINES = 52;

    logic       CLOCK = 1'b0;
    logic       nRESET = 1'b0;
    logic       CLKEN = 1'b0;
    logic       HSYNC_IN = 1'b0;
    logic       VSYNC_IN = 1'b0;
    logic       INT_ACK = 1'b0;
    logic       RMR_WR = 1'b0;
    logic [4:0] RMR_DI = 5'd0;
    logic       INT;
    logic       HSYNC_OUT;
    logic       VSYNC_OUT;
    logic [1:0] MODE;
    logic [5:0] R52;

    ga_sync_int #(
        .HS_DELAY(HS_DELAY), .HS_WIDTH(HS_WIDTH),
        .VS_DELAY(VS_DELAY), .VS_WIDTH(VS_WIDTH), .INT_LINES(INT_LINES)
    ) dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
        .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .INT_ACK(INT_ACK), .RMR_WR(RMR_WR), .RMR_DI(RMR_DI),
        .INT(INT), .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT),
        .MODE(MODE), .R52(R52)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic       intr;
        logic [5:0] r52;
        logic       hs;
        logic       vs;
        logic [1:0] mode;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_hs_run, m_vs_lines, m_r52, m_mode, m_pend;
    bit m_int, m_hs_prev, m_vs_prev, m_hs_out, m_vs_out;

    int ack_pm = 0;
    int rmr_pm = 0;
    bit force_coinc = 1'b0;
    bit reset_req = 1'b0;
    bit hold_reset = 1'b1;

    task automatic model_step(bit rl, bit ce, bit hs, bit vs, bit ack, bit wr, logic [4:0] di);
        bit fall, vrise, resync, set;
        int nr;
        bit ni;
        if (!rl) begin
            m_hs_run = 0; m_vs_lines = 0; m_r52 = 0; m_mode = 0; m_pend = 0;
            m_int = 0; m_hs_prev = 0; m_vs_prev = 0; m_hs_out = 0; m_vs_out = 0;
            return;
        end
        fall  = ce && m_hs_prev && !hs;
        vrise = ce && !m_vs_prev && vs;
        nr = m_r52; ni = m_int; set = 0;
        if (fall) begin
            resync = vs && !vrise && (m_vs_lines + 1 == VS_DELAY);
            if (resync) begin
                nr = 0;
                if (m_r52 >= 32 || m_r52 + 1 == INT_LINES) begin ni = 1; set = 1; end
            end else if (m_r52 + 1 == INT_LINES) begin
                nr = 0; ni = 1; set = 1;
            end else begin
                nr = m_r52 + 1;
            end
        end
        if (ack) begin
            nr = nr % 32;
            if (!set) ni = 0;
        end
        if (wr && di[4]) begin nr = 0; ni = 0; end
        if (ce) begin
            if (hs && m_hs_run == 0) m_mode = m_pend;
            m_hs_run = hs ? m_hs_run + 1 : 0;
            m_hs_out = hs && m_hs_run > HS_DELAY && m_hs_run <= HS_DELAY + HS_WIDTH;
            if (vrise) m_vs_lines = 0;
            else if (fall && vs) m_vs_lines++;
            m_vs_out = vs && m_vs_lines >= VS_DELAY && m_vs_lines < VS_DELAY + VS_WIDTH;
            m_hs_prev = hs;
            m_vs_prev = vs;
        end
        if (wr) m_pend = int'(di[1:0]);
        m_r52 = nr;
        m_int = ni;
    endtask

    // one CLOCK of stimulus; strobes are random, biased onto critical edges
    task automatic tick(bit ce, bit hs, bit vs);
        bit ack, wr, rl, fall_now, crit;
        logic [4:0] di;
        @(negedge CLOCK);
        fall_now = ce && m_hs_prev && !hs;
        crit = fall_now && (m_r52 == INT_LINES - 1 ||
                            (vs && m_vs_prev && m_vs_lines + 1 == VS_DELAY));
        ack = ($urandom_range(0, 999) < ack_pm);
        wr  = ($urandom_range(0, 999) < rmr_pm);
        di  = 5'($urandom);
        di[4] = ($urandom_range(0, 7) == 0);
        if (crit && force_coinc) begin
            ack = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                wr = 1'b1;
                di = 5'b10010;
            end
        end
        rl = !hold_reset && !(reset_req && m_int && hs && m_hs_prev);
        if (!rl && !hold_reset) reset_req = 1'b0;
        nRESET = rl; CLKEN = ce; HSYNC_IN = hs; VSYNC_IN = vs;
        INT_ACK = ack; RMR_WR = wr; RMR_DI = di;
        model_step(rl, ce, hs, vs, ack, wr, di);
        exp_q.push_back(exp_t'{m_int, 6'(m_r52), m_hs_out, m_vs_out, 2'(m_mode)});
    endtask

    task automatic one_char(bit hs, bit vs);
        int idle;
        idle = $urandom_range(0, 2);
        tick(1'b1, hs, vs);
        for (int i = 0; i < idle; i++) tick(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic frame(int lines, int len, int hs_fixed, int vs_line, int vs_len, int vs_char);
        int hs_w, a, vs_a, vs_b;
        int widths[8] = '{1, 2, 3, 4, 5, 6, 14, 3};
        vs_a = vs_line * len + vs_char;
        vs_b = (vs_line + vs_len) * len + vs_char;
        for (int l = 0; l < lines; l++) begin
            hs_w = (hs_fixed > 0) ? hs_fixed : widths[$urandom_range(0, 7)];
            if (hs_w >= len) hs_w = len - 2;
            for (int c = 0; c < len; c++) begin
                a = l * len + c;
                one_char(c < hs_w, (a >= vs_a) && (a < vs_b));
            end
        end
    endtask

    task automatic chk(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // monitor: every edge presents a full output set, checked against the queue
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("INT", int'(INT), int'(e.intr));
                chk("R52", int'(R52), int'(e.r52));
                chk("HSYNC_OUT", int'(HSYNC_OUT), int'(e.hs));
                chk("VSYNC_OUT", int'(VSYNC_OUT), int'(e.vs));
                chk("MODE", int'(MODE), int'(e.mode));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lines, vlen;
        int vlens[4] = '{1, 3, 16, 5};
        hold_reset = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        hold_reset = 1'b0;

        // steady 64-char lines, wide HSYNC, no VSYNC, no strobes
        frame(56, 64, 14, 0, 0, 0);

        // random frames with VSYNC, acks and RMR writes
        ack_pm = 5; rmr_pm = 2; force_coinc = 1'b1;
        for (int f = 0; f < 14; f++) begin
            lines = $urandom_range(30, 70);
            vlen  = (f < 8) ? vlens[f % 4] : $urandom_range(1, 8);
            frame(lines, 16, 0, $urandom_range(0, lines - 1), vlen, $urandom_range(0, 15));
        end

        // reset asserted mid-HSYNC while an interrupt is pending
        ack_pm = 0; rmr_pm = 0; force_coinc = 1'b0; reset_req = 1'b1;
        frame(60, 16, 6, 0, 0, 0);
        reset_req = 1'b0;
        frame(4, 16, 5, 1, 2, 3);

        @(posedge CLOCK);
        @(posedge CLOCK);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL too_few_comparisons: got %0d expected at least 12", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ga_sync_int.md
Name: ga_sync_int

Overview:
Gate-array-side receiver of the CRTC sync outputs for the CPC core. It consumes raw CRTC HSYNC/VSYNC and produces three things:
- The shaped monitor syncs (delayed and width-limited).
- The Z80 raster interrupt, from the 52-line counter with VSYNC resynchronisation and acknowledge handling.
- The HSYNC-latched screen mode used by the pixel path.

It sits between the CRTC and the video/CPU glue.

Parameters:
HS_DELAY, 2, chars from first sampled CRTC HSYNC to monitor HSYNC start
HS_WIDTH, 4, maximum monitor HSYNC width in chars
VS_DELAY, 2, CRTC HSYNC falling edges from CRTC VSYNC start to monitor VSYNC start and interrupt resync
VS_WIDTH, 4, maximum monitor VSYNC width in HSYNC lines
INT_LINES, 52, line count at which the interrupt counter wraps and raises INT

Ports:
CLOCK  in  1  system clock
nRESET  in  1  synchronous, active-low reset
CLKEN  in  1  1 MHz char-clock enable, same enable that drives the CRTC
HSYNC_IN  in  1  CRTC HSYNC
VSYNC_IN  in  1  CRTC VSYNC
INT_ACK  in  1  one-CLOCK strobe, Z80 interrupt acknowledge (M1 & IORQ)
RMR_WR  in  1  one-CLOCK strobe, gate-array RMR write
RMR_DI  in  5  RMR data bits [4:0]; bit4 = interrupt counter reset, [1:0] = mode
INT  out  1  interrupt request, active high
HSYNC_OUT  out  1  monitor HSYNC
VSYNC_OUT  out  1  monitor VSYNC
MODE  out  2  active screen mode
R52  out  6  interrupt line counter (debug/status)

Behaviour:
Reset:
- Reset is synchronous and active-low: nRESET low on a CLOCK edge clears all state.
- INT=0, HSYNC_OUT=0, VSYNC_OUT=0, MODE=0, R52=0, pending mode=0; all internal counters and edge-detection history 0.

Sampling:
- HSYNC_IN and VSYNC_IN are sampled only on CLKEN.
- An edge is prev≠current between consecutive CLKEN samples.

Horizontal shaping:
- hs_cnt is 4 bits, saturating at 15.
- On CLKEN: n = HSYNC_IN ? sat(hs_cnt+1) : 0; hs_cnt <= n.
- HSYNC_OUT <= HSYNC_IN & (n > HS_DELAY) & (n <= HS_DELAY+HS_WIDTH).
- Worked example: first high sample at CLKEN k gives HSYNC_OUT high for k+2 .. k+5, or until HSYNC_IN falls, whichever is first. A CRTC width ≤ HS_DELAY produces no monitor pulse.

Mode latch:
- RMR_WR stores RMR_DI[1:0] into the pending mode on every RMR_WR.
- MODE <= pending on the CLKEN where n==1 (HSYNC rising).
- A write in the same CLOCK as that CLKEN is applied at the next HSYNC, not this one.

Vertical shaping:
- vs_cnt is 3 bits, saturating.
- Reset to 0 on the CLKEN where VSYNC_IN rises.
- Increments on each HSYNC falling edge while VSYNC_IN=1.
- VSYNC_OUT = VSYNC_IN & (vs_cnt >= VS_DELAY) & (vs_cnt < VS_DELAY+VS_WIDTH), registered.
- VSYNC_IN falling forces VSYNC_OUT=0 on that CLKEN.

Interrupt counter (evaluated on CLKEN with an HSYNC falling edge; let inc = R52+1):
- Resync edge (this edge takes vs_cnt to VS_DELAY while VSYNC_IN=1): R52 <= 0; INT <= 1 if R52 >= 32 or inc == INT_LINES; INT otherwise unchanged.
- Otherwise, inc == INT_LINES: R52 <= 0, INT <= 1.
- Otherwise: R52 <= inc.

Acknowledge:
- INT_ACK: INT <= 0 and R52[5] <= 0, applied to the post-update value of the same cycle.
- If a set (wrap or resync) and INT_ACK coincide, the set wins (INT=1) and R52 stays 0.

RMR counter reset:
- RMR_WR with RMR_DI[4]=1: R52 <= 0, INT <= 0.
- Highest priority: overrides a same-cycle wrap, resync or ack.

Edge behaviour is CLKEN-qualified; strobes act on any CLOCK.

Latency:
- All outputs are registered.
- INT is visible 1 CLOCK after the qualifying CLKEN edge.

Decomposition:
- ga_pkg holds the constants INT_LINES, INT_RESYNC_MIN (=32) and the RMR bit indices (RMR_INT_RST=4, RMR_MODE=[1:0]).
- One sub-module, ga_sync_shaper, is instanced twice:
  - step input (CLKEN for H, HSYNC falling edge for V);
  - level input (HSYNC_IN / VSYNC_IN);
  - DELAY/WIDTH parameters;
  - outputs the count and the shaped pulse.

Test Plan:
- Steady frame, 64-char lines, CRTC HSYNC width 14, no VSYNC -> INT rises after the 52nd HSYNC falling edge, R52 cycles 0..51, HSYNC_OUT exactly 4 chars starting 2 chars after first HSYNC sample.
- INT pending at R52=0, INT_ACK -> INT=0; then preload R52=40 and ack -> R52=8, next INT after 44 more lines.
- VSYNC start with R52=40 -> on 2nd HSYNC falling edge INT=1 and R52=0; repeat with R52=20 -> INT stays 0, R52=0.
- CRTC HSYNC width 3 -> HSYNC_OUT 1 char; width 2 -> no pulse. VSYNC_IN 16 lines -> VSYNC_OUT lines 2..5 only; VSYNC_IN 3 lines -> VSYNC_OUT 1 line.
- RMR_WR DI=5'b10010 in the same CLOCK as the R52 wrap and an INT_ACK -> INT=0, R52=0. MODE changes to 2 only at the next HSYNC rising sample.
- nRESET low mid-HSYNC with INT=1 -> on the next CLOCK all outputs 0. After release, HSYNC_OUT does not assert until a fresh HSYNC rising sample.
